// File: rtl/contin_mode_sched.sv
// contin_mode_sched: frames the 25 MHz sample stream into FIFO1 as a zero marker, FRAME_LEN samples, then a gap.
// Define CONTIN_SCHED_TRAILER_EN to append a frame-count trailer word after each completed frame.
module contin_mode_sched #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 256,
  parameter int GAP_CYC   = 8
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic              cmd_open,
  input  logic              cmd_close,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              fifo_full1_in,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              contin_busy,
  output logic [15:0]       frame_cnt,
  output logic              overflow_err
);

`ifdef CONTIN_SCHED_TRAILER_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BURST, S_GAP, S_TRAIL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BURST, S_GAP} state_t;
`endif

  localparam logic [15:0] LP_WORD_LAST = 16'(FRAME_LEN - 1);
  localparam logic [7:0]  LP_GAP_LAST  = 8'(GAP_CYC - 1);

  // Zero is the frame delimiter, so payload zeros are nudged to one.
  function automatic logic [DATA_W-1:0] f_sub_zero(input logic [DATA_W-1:0] d);
    return (d == '0) ? DATA_W'(1) : d;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_word_cnt, w_word_cnt_nxt;
  logic [7:0]          r_gap_cnt, w_gap_cnt_nxt;
  logic                r_close_pend, w_close_nxt;
  logic [15:0]         r_frame_cnt, w_frame_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                r_wr_en_p1, w_wr_en;
  logic [DATA_W-1:0]   r_wr_data_p1, w_wr_data;
  logic                w_close_eff;

  assign w_close_eff = r_close_pend | cmd_close;

  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_close_nxt    = r_close_pend;
    w_frame_nxt    = r_frame_cnt;
    w_ovf_nxt      = r_ovf;
    w_wr_en        = 1'b0;
    w_wr_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_open && !cmd_close) w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (cmd_close) begin
          w_state_nxt = S_IDLE;
        end else if (!fifo_full1_in) begin
          w_wr_en        = 1'b1;
          w_word_cnt_nxt = '0;
          w_state_nxt    = S_BURST;
        end
      end
      S_BURST: begin
        if (cmd_close) w_close_nxt = 1'b1;
        if (sample_valid) begin
          if (fifo_full1_in) begin
            // Dropped sample poisons the frame; restart with a fresh marker.
            w_ovf_nxt   = 1'b1;
            w_state_nxt = w_close_eff ? S_IDLE : S_SYNC;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_data = f_sub_zero(sample_data);
            if (r_word_cnt == LP_WORD_LAST) begin
              w_frame_nxt    = r_frame_cnt + 16'd1;
              w_word_cnt_nxt = '0;
              w_gap_cnt_nxt  = '0;
`ifdef CONTIN_SCHED_TRAILER_EN
              w_state_nxt    = S_TRAIL;
`else
              w_state_nxt    = w_close_eff ? S_IDLE : S_GAP;
`endif
            end else begin
              w_word_cnt_nxt = r_word_cnt + 16'd1;
            end
          end
        end
      end
      S_GAP: begin
        if (w_close_eff) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == LP_GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = S_SYNC;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end
`ifdef CONTIN_SCHED_TRAILER_EN
      S_TRAIL: begin
        if (cmd_close) w_close_nxt = 1'b1;
        if (!fifo_full1_in) begin
          w_wr_en       = 1'b1;
          w_wr_data     = (r_frame_cnt == 16'd0) ? DATA_W'(1) : DATA_W'(r_frame_cnt);
          w_gap_cnt_nxt = '0;
          w_state_nxt   = w_close_eff ? S_IDLE : S_GAP;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_IDLE) w_close_nxt = 1'b0;
  end

  // Stage p1: registered FIFO write port and control state
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_close_pend <= 1'b0;
      r_frame_cnt  <= '0;
      r_ovf        <= 1'b0;
      r_wr_en_p1   <= 1'b0;
      r_wr_data_p1 <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_close_pend <= w_close_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_ovf        <= w_ovf_nxt;
      r_wr_en_p1   <= w_wr_en;
      r_wr_data_p1 <= w_wr_data;
    end
  end

  assign fifo_wr_en   = r_wr_en_p1;
  assign fifo_wr_data = r_wr_data_p1;
  assign contin_busy  = (r_state != S_IDLE);
  assign frame_cnt    = r_frame_cnt;
  assign overflow_err = r_ovf;

endmodule

// File: doc/contin_mode_sched.md
# contin_mode_sched

Continuous-mode acquisition scheduler for the 25 MHz correlation sample path. It sequences open/close commands into framed bursts written to FIFO1: each frame is one zero marker word followed by FRAME_LEN samples, then a fixed gap. The zero word is reserved as the frame delimiter that the downstream continuous-mode gate keys on. The block also handles FIFO back-pressure and overflow, and counts completed frames.

## Interface
- DATA_W, 16, sample and FIFO word width
- FRAME_LEN, 256, samples per frame (2..65535)
- GAP_CYC, 8, idle cycles between frames (1..255)
- clk_25m  in  1  system clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- cmd_open  in  1  single-cycle pulse; start continuous mode
- cmd_close  in  1  single-cycle pulse; stop continuous mode
- sample_valid  in  1  sample_data valid this cycle (no back-pressure upstream)
- sample_data  in  DATA_W  raw sample
- fifo_full1_in  in  1  FIFO1 full flag
- fifo_wr_en  out  1  FIFO1 write strobe (registered)
- fifo_wr_data  out  DATA_W  FIFO1 write word (registered)
- contin_busy  out  1  high in every state except IDLE
- frame_cnt  out  16  completed frames since reset; wraps 0xFFFF->0
- overflow_err  out  1  sticky; set on any dropped in-frame sample; cleared only by rst

## Operation
- States: IDLE, SYNC, BURST, GAP, TRAIL (TRAIL exists only with the macro).
- IDLE: cmd_open -> SYNC. Samples are ignored.
- SYNC: when fifo_full1_in=0, write 0x0000, clear word counter, -> BURST. While full, hold without writing. No overflow is flagged in SYNC.
- BURST: each sample_valid with fifo_full1_in=0 writes the sample and increments the counter.
  - A sample_data of 0 is written as 0x0001, so the marker stays unique.
  - Counter reaching FRAME_LEN completes the frame: frame_cnt+1, then -> GAP (or TRAIL).
- BURST overflow: sample_valid with fifo_full1_in=1 drops the sample, sets overflow_err and aborts the frame.
  - An aborted frame goes to SYNC; frame_cnt is not incremented.
  - The next frame begins with a fresh marker.
- GAP: counts GAP_CYC cycles with samples silently dropped, then -> SYNC. A pending close -> IDLE instead.
- cmd_close:
  - In BURST (or TRAIL), latched as close_pend; the current frame completes and the block goes to IDLE. The GAP is skipped.
  - In SYNC or GAP, -> IDLE next cycle with no write.
  - In IDLE, ignored.
- cmd_open outside IDLE is ignored. cmd_open and cmd_close in the same cycle: close wins (IDLE stays IDLE).
- close_pend clears on entering IDLE.
- An abort while close_pend is set -> IDLE, not SYNC.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=0, contin_busy=0, frame_cnt=0, overflow_err=0, state IDLE, counters 0.
- Write decision made in cycle N from fifo_full1_in and sample_valid in cycle N; fifo_wr_en/fifo_wr_data appear in cycle N+1.
- fifo_wr_en is high for exactly one cycle per written word.
- cmd_open at cycle N: state SYNC at N+1; marker written at N+2 on the FIFO interface if not full.
- Final sample write and the frame_cnt increment are visible in the same cycle.
- contin_busy tracks state and goes high one cycle after cmd_open.
- rst mid-frame aborts immediately with no further writes. A partial frame left in the FIFO is the consumer's concern.
- Minimum frame period with continuous samples: 1 + FRAME_LEN + GAP_CYC cycles (+1 with trailer).

## Configuration
- CONTIN_SCHED_TRAILER_EN defined:
  - After FRAME_LEN samples, state TRAIL writes one trailer word = frame_cnt value after increment, with 0 substituted by 0x0001.
  - TRAIL waits while fifo_full1_in=1; waiting here is not an overflow.
  - TRAIL -> GAP, or IDLE if close_pend.
- Undefined: TRAIL is absent and BURST goes directly to GAP/IDLE.

## Test plan
- FRAME_LEN=4, GAP_CYC=2, continuous samples 5,6,7,8,9.. after cmd_open -> FIFO sees 0,5,6,7,8; 2 idle cycles; 0, next samples; frame_cnt=1 after first frame.
- Sample value 0 inside a frame -> written as 0x0001; no extra marker appears.
- fifo_full1_in high for one cycle mid-frame with a valid sample -> sample dropped, overflow_err=1 sticky, new 0 marker follows, frame_cnt unchanged.
- cmd_close at the 2nd sample of a 4-sample frame -> remaining 2 samples written, then IDLE, contin_busy=0, no GAP; cmd_close while IDLE has no effect.
- Simultaneous cmd_open+cmd_close in IDLE -> stays IDLE. With CONTIN_SCHED_TRAILER_EN, the first frame ends with trailer word 0x0001.
- rst asserted during BURST -> next cycle all outputs 0, state IDLE; cmd_open restarts with a marker.
